// File: rtl/i2s_tx_if.sv
// Sample-pair handoff channel into the I2S transmitter.
// The producer drives a stereo pair with in_valid; the transmitter answers with in_ready.
interface i2s_tx_if;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output in_left,
        output in_right,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_left,
        input  in_right,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/i2s_tx.sv
// I2S master transmitter: 64-slot frames, 16-bit left/right samples MSB-first,
// with a one-deep pending buffer that is latched into the active pair at each frame start.
module i2s_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic       en,
    i2s_tx_if.slave    smp,
    output logic       sck,
    output logic       ws,
    output logic       sd,
    output logic [5:0] frame_posn,
    output logic       frame_start,
    output logic       underrun
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SMP_W = 16;
    localparam int unsigned POS_W = 6;
    localparam int unsigned SLT_W = 5;
    localparam int unsigned BIT_W = 4;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [POS_W-1:0] POSN_IDLE = POS_W'(63);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_d;
    logic               sck_d;
    logic               ws_d;
    logic               sd_d;
    logic [POS_W-1:0]   posn_d;
    logic               fs_d;
    logic               ur_d;

    logic               pend_empty_q;
    logic               pend_empty_d;
    logic [SMP_W-1:0]   pend_l_q;
    logic [SMP_W-1:0]   pend_l_d;
    logic [SMP_W-1:0]   pend_r_q;
    logic [SMP_W-1:0]   pend_r_d;
    logic [SMP_W-1:0]   act_l_q;
    logic [SMP_W-1:0]   act_l_d;
    logic [SMP_W-1:0]   act_r_q;
    logic [SMP_W-1:0]   act_r_d;

    logic               tick_c;
    logic [POS_W-1:0]   posn_nx_c;
    logic [SLT_W-1:0]   slot_c;
    logic [BIT_W-1:0]   bit_c;
    logic               data_slot_c;
    logic               accept_c;

    // The pending buffer state is itself the ready flag, so there is no path from in_valid.
    assign smp.in_ready = pend_empty_q;

    // Next-state and datapath decode.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        sck_d        = sck;
        ws_d         = ws;
        sd_d         = sd;
        posn_d       = frame_posn;
        fs_d         = 1'b0;
        ur_d         = 1'b0;
        pend_empty_d = pend_empty_q;
        pend_l_d     = pend_l_q;
        pend_r_d     = pend_r_q;
        act_l_d      = act_l_q;
        act_r_d      = act_r_q;

        tick_c      = (div_q == DIV_LAST);
        posn_nx_c   = frame_posn + POS_W'(1);
        // Both halves use the same in-half slot pattern: slots 1..16 carry bit (16 - slot).
        slot_c      = posn_nx_c[SLT_W-1:0];
        bit_c       = BIT_W'(SLT_W'(16) - slot_c);
        data_slot_c = (slot_c != '0) && (slot_c <= SLT_W'(16));
        accept_c    = smp.in_valid && pend_empty_q;

        case (state_q)
            IDLE:    if (en)  state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((state_q == IDLE) || !en) begin
            div_d  = '0;
            sck_d  = 1'b0;
            ws_d   = 1'b0;
            sd_d   = 1'b0;
            posn_d = POSN_IDLE;
        end else if (!tick_c) begin
            div_d = div_q + DIV_W'(1);
        end else begin
            div_d = '0;
            sck_d = !sck;
            // Falling sck edge: advance the slot so data is stable before the next rising edge.
            if (sck) begin
                posn_d = posn_nx_c;
                ws_d   = posn_nx_c[POS_W-1];
                sd_d   = data_slot_c &&
                         (posn_nx_c[POS_W-1] ? act_r_q[bit_c] : act_l_q[bit_c]);
                if (posn_nx_c == '0) begin
                    fs_d = 1'b1;
                    if (!pend_empty_q) begin
                        act_l_d      = pend_l_q;
                        act_r_d      = pend_r_q;
                        pend_empty_d = 1'b1;
                    end else begin
                        act_l_d = '0;
                        act_r_d = '0;
                        ur_d    = 1'b1;
                    end
                end
            end
        end

        // A pair arriving on a frame-0 underrun lands in the buffer for the following frame.
        if (accept_c) begin
            pend_empty_d = 1'b0;
            pend_l_d     = smp.in_left;
            pend_r_d     = smp.in_right;
        end
    end

    // State and output registers.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            div_q        <= '0;
            sck          <= 1'b0;
            ws           <= 1'b0;
            sd           <= 1'b0;
            frame_posn   <= POSN_IDLE;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            pend_empty_q <= 1'b1;
            pend_l_q     <= '0;
            pend_r_q     <= '0;
            act_l_q      <= '0;
            act_r_q      <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            sck          <= sck_d;
            ws           <= ws_d;
            sd           <= sd_d;
            frame_posn   <= posn_d;
            frame_start  <= fs_d;
            underrun     <= ur_d;
            pend_empty_q <= pend_empty_d;
            pend_l_q     <= pend_l_d;
            pend_r_q     <= pend_r_d;
            act_l_q      <= act_l_d;
            act_r_q      <= act_r_d;
        end
    end

endmodule
